muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle RISC-V core. It consumes the two register-file read operands (rs1/rs2 data), computes one of the eight M-extension operations over a fixed number of cycles while holding the core stalled through `busy`, then presents a result on the register-file write port (`waddr`/`wdata`/`reg_wr`). It sits between the register-file read ports and the writeback mux, alongside the ALU.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state on the next posedge.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  input  32  operand A (dividend / multiplicand).
- rs2_data  input  32  operand B (divisor / multiplier).
- rd_addr  input  5  destination register, captured with start.
- kill  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  high in every non-IDLE state; the core stalls its PC on it.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  result; held until the next accepted start.
- waddr  output  5  captured rd_addr; held like result.
- reg_wr  output  1  equals done AND (waddr != 0).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1: capture funct3 and rd_addr. Load |A| and |B|. Operands are treated as signed per op: MULH/DIV/REM treat A and B as signed; MULHSU treats A as signed and B as unsigned; MULHU/DIVU/REMU/MUL treat both as unsigned. MUL's low word is sign-agnostic. Record the result sign. Set count=0 and go to CALC.
- CALC, multiply: shift-add of the 32-bit magnitudes into a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- CALC exit: after 32 iterations (count 0..31) go to FIX.
- FIX, negation: negate the 64-bit product if the signs differ. Negate the quotient if sign(A)≠sign(B). Negate the remainder if A is negative.
- FIX, result select: MUL takes low[31:0]; MULH/MULHSU/MULHU take high[63:32]; DIV/DIVU take the quotient; REM/REMU take the remainder. Register the selected value into result and go to DONE.
- Divide by zero, overriding the computed value: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = A.
- Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Special cases keep the full latency; there is no early-out.
- DONE: assert done (and reg_wr per rule), then go to IDLE on the next posedge.
- kill=1 in CALC or FIX: go to IDLE on the next posedge. No done and no reg_wr are produced; result and waddr keep their previous values.
- kill in DONE has no effect; the pulse completes. kill in IDLE is ignored.
- start while busy (including DONE) is ignored and no request is queued. Operands are not re-sampled after capture, so rs1/rs2 may change freely.

## Timing
- Reset values: state=IDLE, busy=0, done=0, reg_wr=0, result=0, waddr=0, count=0.
- Cycle numbering: start is high in cycle 0 and sampled at the end of cycle 0.
- Cycles 1–32: CALC, busy=1.
- Cycle 33: FIX, busy=1.
- Cycle 34: DONE, busy=1, done=1.
- Cycle 35: IDLE, busy=0. A new start can be sampled at the end of cycle 35 at the earliest.
- Latency is fixed at 34 cycles from the start-sampling edge to done for all ops and operands. Throughput is one op per 35 cycles.
- reset high at any posedge overrides kill, start and every state; all outputs are at reset values in the following cycle.
- busy and done are registered (state decode only); no combinational path from inputs to outputs.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD, rd=5 → done exactly 34 cycles after start, result=0xFFFFFFEB, waddr=5, reg_wr=1 for one cycle.
- MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF → 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV −7/2 and REM −7/2 (A=0xFFFFFFF9, B=2) → 0xFFFFFFFD and 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- Corner cases:
  - DIV/DIVU by 0 with A=0x1234 → 0xFFFFFFFF; REM/REMU → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - Each case at latency 34.
- rd=0 → done=1, reg_wr=0.
- kill in cycle 10 → busy low in cycle 11, no done, result unchanged.
- reset in cycle 20 → all outputs 0 next cycle.
- start pulsed in cycles 5 and 34 → ignored.
- Back-to-back start in cycle 35 → accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps, then a
// sign-fix/select cycle and a one-cycle done pulse. Fixed 34-cycle latency for all ops.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      waddr,
  output logic            reg_wr
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        count_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_raw_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic              neg_a_q, neg_b_q, b_zero_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        waddr_q;

  logic              a_signed, b_signed, in_neg_a, in_neg_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic              prod_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  // Operand magnitudes and signs at capture time
  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    in_neg_a = a_signed && rs1_data[XLEN-1];
    in_neg_b = b_signed && rs2_data[XLEN-1];
    abs_a    = in_neg_a ? (0 - rs1_data) : rs1_data;
    abs_b    = in_neg_b ? (0 - rs2_data) : rs2_data;
  end

  // One iteration step: acc_q low half is the multiplier (mul) or dividend/quotient (div)
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_sub   = div_shift[XLEN-1:0] - opb_q;
  end

  always_comb begin
    prod_neg = neg_a_q ^ neg_b_q;
    prod_fix = prod_neg ? (0 - acc_q) : acc_q;
    quo_fix  = prod_neg ? (0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? (0 - rem_q) : rem_q;
    if (b_zero_q) begin
      quo_fix = '1;
      rem_fix = a_raw_q;
    end
    case (op_q)
      3'd0:             fix_result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_result = quo_fix;
      default:          fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StCalc;
      StCalc: begin
        if (kill)                 state_d = StIdle;
        else if (count_q == 5'd31) state_d = StFix;
      end
      StFix:  state_d = kill ? StIdle : StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_raw_q  <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= funct3;
            rd_q     <= rd_addr;
            a_raw_q  <= rs1_data;
            neg_a_q  <= in_neg_a;
            neg_b_q  <= in_neg_b;
            b_zero_q <= (rs2_data == '0);
            count_q  <= '0;
            rem_q    <= '0;
            // Multiply: multiplier B in the low half; divide: dividend A in the low half
            opb_q    <= funct3[2] ? abs_b : abs_a;
            acc_q    <= {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
          end
        end
        StCalc: begin
          count_q <= count_q + 5'd1;
          if (!op_q[2]) begin
            acc_q <= mul_next;
          end else begin
            acc_q[XLEN-1:0] <= {acc_q[XLEN-2:0], div_ge};
            rem_q           <= div_ge ? div_sub : div_shift[XLEN-1:0];
          end
        end
        StFix: begin
          if (!kill) begin
            result_q <= fix_result;
            waddr_q  <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign waddr  = waddr_q;
  assign reg_wr = done && (waddr_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised + directed bench for muldiv_unit; a scoreboard queue holds expected results,
// and a negedge monitor checks each done pulse against it.
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        kill = 1'b0;
  logic        busy, done, reg_wr;
  logic [31:0] result;
  logic [4:0]  waddr;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_addr(rd_addr), .kill(kill), .busy(busy), .done(done),
    .result(result), .waddr(waddr), .reg_wr(reg_wr)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    logic        wr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_wa = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: plain 64-bit / integer arithmetic on the RV32M definitions
  function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    longint      ua = longint'({32'h0, a});
    longint      ub = longint'({32'h0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (reg_wr && !done) begin
      checks++; errors++;
      $display("FAIL reg_wr_without_done: got reg_wr=1 expected 0 (cycle %0d)", cyc);
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("waddr", waddr, e.wa);
        check("reg_wr", reg_wr, e.wr);
        check("latency", cyc - e.cyc, 34);
        last_res = e.res;
        last_wa  = e.wa;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 stray starts in cycles 5/34 plus kill in IDLE and DONE,
  //       2 kill in cycle 10, 3 kill in FIX, 4 reset in cycle 20
  task automatic run_op(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                        int mode);
    exp_t e;
    int   c0 = cyc;
    int   idle_at = -1;
    int   want;
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    kill = (mode == 1);
    if (mode <= 1) begin
      e.res = model(f, a, b); e.wa = rd; e.wr = (rd != 0); e.cyc = c0;
      sb.push_back(e);
    end
    step();
    for (int i = 1; i <= 40; i++) begin
      start = 1'b0; kill = 1'b0; reset = 1'b0;
      if (mode == 4 && i == 21)
        check("reset_outputs", {busy, done, reg_wr, waddr, result}, 64'h0);
      if (!busy) begin
        idle_at = i;
        break;
      end
      funct3 = 3'($urandom()); rs1_data = $urandom(); rs2_data = $urandom();
      rd_addr = 5'($urandom());
      if (mode == 1 && (i == 5 || i == 34)) start = 1'b1;
      if (mode == 1 && i == 34) kill = 1'b1;
      if (mode == 2 && i == 10) kill = 1'b1;
      if (mode == 3 && i == 33) kill = 1'b1;
      if (mode == 4 && i == 20) reset = 1'b1;
      step();
    end
    case (mode)
      2:       want = 11;
      3:       want = 34;
      4:       want = 21;
      default: want = 35;
    endcase
    check("idle_cycle", idle_at, want);
    if (mode == 2 || mode == 3) begin
      check("kill_result_held", result, last_res);
      check("kill_waddr_held", waddr, last_wa);
    end
    if (mode == 4) begin
      last_res = '0;
      last_wa  = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    step();
    step();
    check("reset_state", {busy, done, reg_wr, waddr, result}, 64'h0);
    reset = 1'b0;
    step();
    check("idle_after_reset", {busy, done, reg_wr}, 3'b000);

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 0);
    run_op(3'd4, 32'h0000_1234, 32'h0, 5'd13, 0);
    run_op(3'd5, 32'h0000_1234, 32'h0, 5'd14, 0);
    run_op(3'd6, 32'h0000_1234, 32'h0, 5'd15, 0);
    run_op(3'd7, 32'h0000_1234, 32'h0, 5'd16, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 0);
    run_op(3'd0, 32'h0000_0003, 32'h0000_0004, 5'd0, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0005, 5'd19, 1);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 2);
    run_op(3'd4, 32'hDEAD_BEEF, 32'h0000_0013, 5'd21, 3);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 4);
    run_op(3'd7, 32'hFFFF_FFF0, 32'h0000_0007, 5'd23, 0);

    for (int n = 0; n < 48; n++) begin
      run_op(3'($urandom()), pick(), pick(), 5'($urandom()), ($urandom_range(0, 5) == 0) ? 1 : 0);
    end

    step();
    step();
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
